// File: rtl/init_sequencer_pkg.sv
// rtl/init_sequencer_pkg.sv - shared states, defaults and fixed slot schedule for init_sequencer
package init_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_DATA_W    = 3;
    localparam int DEF_NUM_SLOTS = 5;
    localparam int DEF_CNT_W     = 6;
    localparam int LAST_OFFSET   = 50;

    localparam int SLOT2_OFFSET = 10;
    localparam int SLOT3_OFFSET = 20;
    localparam int SLOT4_OFFSET = LAST_OFFSET;

    localparam logic [DEF_DATA_W-1:0] SLOT2_VALUE = 3'b001;
    localparam logic [DEF_DATA_W-1:0] SLOT3_VALUE = 3'b100;
    localparam logic [DEF_DATA_W-1:0] SLOT4_VALUE = 3'b101;

    // Offset 0 marks a slot that captures an operand at launch.
    function automatic int slot_offset(input int idx);
        case (idx)
            2:       return SLOT2_OFFSET;
            3:       return SLOT3_OFFSET;
            4:       return SLOT4_OFFSET;
            default: return 0;
        endcase
    endfunction

    function automatic logic [DEF_DATA_W-1:0] slot_const(input int idx);
        case (idx)
            2:       return SLOT2_VALUE;
            3:       return SLOT3_VALUE;
            4:       return SLOT4_VALUE;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/seq_cycle_counter.sv
// rtl/seq_cycle_counter.sv - loadable up-counter with clear, enable and terminal-count match
module seq_cycle_counter #(
    parameter int CNT_W    = 6,
    parameter int TERMINAL = 50
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             terminal
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign terminal = (count == CNT_W'(TERMINAL));

endmodule

// File: rtl/init_sequencer.sv
// rtl/init_sequencer.sv - cycle-offset scheduler loading five slot registers; INIT_SEQ_RESTART_EN allows restart outside IDLE
module init_sequencer
    import init_sequencer_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int NUM_SLOTS = DEF_NUM_SLOTS,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [DATA_W-1:0]    in1,
    input  logic [DATA_W-1:0]    in2,
    output logic [DATA_W-1:0]    out1,
    output logic [DATA_W-1:0]    out2,
    output logic [DATA_W-1:0]    out3,
    output logic [DATA_W-1:0]    out4,
    output logic [DATA_W-1:0]    out5,
    output logic [NUM_SLOTS-1:0] loaded,
    output logic                 busy,
    output logic                 done
);

    state_t                 state;
    state_t                 state_next;
    logic [DATA_W-1:0]      slot_q   [NUM_SLOTS];
    logic [DATA_W-1:0]      slot_src [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]   slot_en;
    logic [NUM_SLOTS-1:0]   loaded_next;
    logic                   launch;
    logic                   cnt_clear;
    logic                   cnt_load;
    logic                   cnt_en;
    logic                   cnt_last;
    logic [CNT_W-1:0]       count;

`ifdef INIT_SEQ_RESTART_EN
    assign launch = start;
`else
    assign launch = start && (state == ST_IDLE);
`endif

    seq_cycle_counter #(
        .CNT_W    (CNT_W),
        .TERMINAL (LAST_OFFSET)
    ) u_counter (
        .clk        (clk),
        .reset      (reset),
        .clear      (cnt_clear),
        .load       (cnt_load),
        .load_value (CNT_W'(1)),
        .enable     (cnt_en),
        .count      (count),
        .terminal   (cnt_last)
    );

    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (i == 0)      slot_src[i] = in1;
            else if (i == 1) slot_src[i] = in2;
            else             slot_src[i] = DATA_W'(slot_const(i));
        end
    end

    // Launch takes priority over abort and over any scheduled load on the same edge.
    always_comb begin
        state_next  = state;
        slot_en     = '0;
        loaded_next = loaded;
        cnt_clear   = 1'b0;
        cnt_load    = 1'b0;
        cnt_en      = 1'b0;
        if (launch) begin
            state_next = ST_RUN;
            cnt_load   = 1'b1;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_en[i] = (slot_offset(i) == 0);
            end
            loaded_next = slot_en;
        end else begin
            case (state)
                ST_RUN: begin
                    if (abort) begin
                        state_next = ST_IDLE;
                        cnt_clear  = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                        for (int i = 0; i < NUM_SLOTS; i++) begin
                            slot_en[i] = (slot_offset(i) != 0) &&
                                         (count == CNT_W'(slot_offset(i)));
                        end
                        loaded_next = loaded | slot_en;
                        if (cnt_last) begin
                            state_next = ST_DONE;
                            cnt_clear  = 1'b1;
                        end
                    end
                end
                ST_DONE: state_next = ST_IDLE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            loaded <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            state  <= state_next;
            loaded <= loaded_next;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (slot_en[i]) slot_q[i] <= slot_src[i];
            end
        end
    end

    assign out1 = slot_q[0];
    assign out2 = slot_q[1];
    assign out3 = slot_q[2];
    assign out4 = slot_q[3];
    assign out5 = slot_q[4];
    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_init_sequencer.sv
// tb/tb_init_sequencer.sv - scoreboard bench for init_sequencer schedule, abort, reset and restart
module tb_init_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic [2:0] in1;
    logic [2:0] in2;
    logic [2:0] out1, out2, out3, out4, out5;
    logic [4:0] loaded;
    logic       busy;
    logic       done;

    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          exp_c[$];
    string       exp_n[$];
    logic [21:0] exp_v[$];
    int          done_c[$];

    init_sequencer dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .abort  (abort),
        .in1    (in1),
        .in2    (in2),
        .out1   (out1),
        .out2   (out2),
        .out3   (out3),
        .out4   (out4),
        .out5   (out5),
        .loaded (loaded),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_at(input int c, input string nm,
                             input logic [2:0] o1, input logic [2:0] o2, input logic [2:0] o3,
                             input logic [2:0] o4, input logic [2:0] o5,
                             input logic [4:0] ld, input logic b, input logic d);
        exp_c.push_back(c);
        exp_n.push_back(nm);
        exp_v.push_back({o1, o2, o3, o4, o5, ld, b, d});
    endtask

    task automatic pulse_start(input logic [2:0] a, input logic [2:0] b, input logic ab);
        in1   = a;
        in2   = b;
        start = 1'b1;
        abort = ab;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: compares DUT state against queued snapshots and checks every done pulse.
    always @(negedge clk) begin
        logic [21:0] act;
        act = {out1, out2, out3, out4, out5, loaded, busy, done};
        while (exp_c.size() > 0 && exp_c[0] <= cyc) begin
            total++;
            if (exp_c[0] < cyc || act !== exp_v[0]) begin
                bad++;
                $display("FAIL %s cyc=%0d act=%h exp=%h", exp_n[0], cyc, act, exp_v[0]);
            end
            void'(exp_c.pop_front());
            void'(exp_n.pop_front());
            void'(exp_v.pop_front());
        end
        if (done === 1'b1) begin
            total++;
            if (done_c.size() == 0 || done_c[0] != cyc) begin
                bad++;
                $display("FAIL done_pulse cyc=%0d act=1 exp=0", cyc);
            end else begin
                void'(done_c.pop_front());
            end
        end
        if (done_c.size() > 0 && done_c[0] < cyc) begin
            total++;
            bad++;
            $display("FAIL done_missing cyc=%0d act=0 exp=1 at cyc %0d", cyc, done_c[0]);
            void'(done_c.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d act=running exp=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        int e0;
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        in1   = '0;
        in2   = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        c = cyc;
        for (int k = 1; k <= 5; k++) expect_at(c + k, "reset_idle", 0, 0, 0, 0, 0, 5'b00000, 0, 0);
        wait_until(c + 5);

        // Full schedule; operands change right after capture.
        e0 = cyc + 1;
        expect_at(e0,      "full_e0",     3, 6, 0, 0, 0, 5'b00011, 1, 0);
        expect_at(e0 + 1,  "full_hold_in",3, 6, 0, 0, 0, 5'b00011, 1, 0);
        expect_at(e0 + 9,  "full_pre10",  3, 6, 0, 0, 0, 5'b00011, 1, 0);
        expect_at(e0 + 10, "full_out3",   3, 6, 1, 0, 0, 5'b00111, 1, 0);
        expect_at(e0 + 19, "full_pre20",  3, 6, 1, 0, 0, 5'b00111, 1, 0);
        expect_at(e0 + 20, "full_out4",   3, 6, 1, 4, 0, 5'b01111, 1, 0);
        expect_at(e0 + 49, "full_pre50",  3, 6, 1, 4, 0, 5'b01111, 1, 0);
        expect_at(e0 + 50, "full_done",   3, 6, 1, 4, 5, 5'b11111, 0, 1);
        expect_at(e0 + 51, "full_idle",   3, 6, 1, 4, 5, 5'b11111, 0, 0);
        done_c.push_back(e0 + 50);
        pulse_start(3'b011, 3'b110, 1'b0);
        in1 = 3'b111;
        in2 = 3'b001;
        wait_until(e0 + 51);

        // Reset mid-run.
        e0 = cyc + 1;
        expect_at(e0 + 29, "rst_pre",   2, 5, 1, 4, 5, 5'b01111, 1, 0);
        expect_at(e0 + 30, "rst_clear", 0, 0, 0, 0, 0, 5'b00000, 0, 0);
        expect_at(e0 + 31, "rst_after", 0, 0, 0, 0, 0, 5'b00000, 0, 0);
        pulse_start(3'b010, 3'b101, 1'b0);
        wait_until(e0 + 29);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wait_until(e0 + 31);

        // Abort at E0+15 leaves partial progress.
        e0 = cyc + 1;
        expect_at(e0 + 10, "abort_out3",  5, 2, 1, 0, 0, 5'b00111, 1, 0);
        expect_at(e0 + 14, "abort_pre",   5, 2, 1, 0, 0, 5'b00111, 1, 0);
        expect_at(e0 + 15, "abort_stop",  5, 2, 1, 0, 0, 5'b00111, 0, 0);
        expect_at(e0 + 60, "abort_hold",  5, 2, 1, 0, 0, 5'b00111, 0, 0);
        pulse_start(3'b101, 3'b010, 1'b0);
        wait_until(e0 + 14);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_until(e0 + 60);

        // Start and abort together in IDLE: start wins, full run follows.
        e0 = cyc + 1;
        expect_at(e0,      "both_e0",   2, 1, 1, 0, 0, 5'b00011, 1, 0);
        expect_at(e0 + 20, "both_out4", 2, 1, 1, 4, 0, 5'b01111, 1, 0);
        expect_at(e0 + 50, "both_done", 2, 1, 1, 4, 5, 5'b11111, 0, 1);
        expect_at(e0 + 51, "both_idle", 2, 1, 1, 4, 5, 5'b11111, 0, 0);
        done_c.push_back(e0 + 50);
        pulse_start(3'b010, 3'b001, 1'b1);
        wait_until(e0 + 51);

        // Second start at E0+5.
        e0 = cyc + 1;
`ifdef INIT_SEQ_RESTART_EN
        expect_at(e0 + 5,  "rs_restart", 7, 0, 1, 4, 5, 5'b00011, 1, 0);
        expect_at(e0 + 14, "rs_pre15",   7, 0, 1, 4, 5, 5'b00011, 1, 0);
        expect_at(e0 + 15, "rs_out3",    7, 0, 1, 4, 5, 5'b00111, 1, 0);
        expect_at(e0 + 25, "rs_out4",    7, 0, 1, 4, 5, 5'b01111, 1, 0);
        expect_at(e0 + 55, "rs_done",    7, 0, 1, 4, 5, 5'b11111, 0, 1);
        expect_at(e0 + 56, "rs_idle",    7, 0, 1, 4, 5, 5'b11111, 0, 0);
        done_c.push_back(e0 + 55);
`else
        expect_at(e0 + 5,  "rs_ignored", 4, 3, 1, 4, 5, 5'b00011, 1, 0);
        expect_at(e0 + 10, "rs_out3",    4, 3, 1, 4, 5, 5'b00111, 1, 0);
        expect_at(e0 + 50, "rs_done",    4, 3, 1, 4, 5, 5'b11111, 0, 1);
        expect_at(e0 + 51, "rs_idle",    4, 3, 1, 4, 5, 5'b11111, 0, 0);
        done_c.push_back(e0 + 50);
`endif
        pulse_start(3'b100, 3'b011, 1'b0);
        wait_until(e0 + 4);
        pulse_start(3'b111, 3'b000, 1'b0);
        wait_until(e0 + 58);

        total++;
        if (exp_c.size() != 0 || done_c.size() != 0) begin
            bad++;
            $display("FAIL leftover act=%0d/%0d exp=0/0", exp_c.size(), done_c.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
